// File: rtl/md_sequencer_if.sv
// Decoder-facing bundle for the multiply/divide sequencer: requests, operands and HI/LO results.
// The EX-stage control drives through master; the sequencer sits on slave.
interface md_sequencer_if;
    logic        start;
    logic [1:0]  MDop;
    logic        MDsign;
    logic        immWrite;
    logic        HIWrite;
    logic        HIRead;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HLOut;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, MDop, MDsign, immWrite, HIWrite, HIRead, A, B,
        input  busy, HLOut, HI, LO
    );

    modport slave (
        input  start, MDop, MDsign, immWrite, HIWrite, HIRead, A, B,
        output busy, HLOut, HI, LO
    );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div sequencer owning HI/LO: the result is computed at launch and held in pend,
// then committed after a fixed latency so the hazard unit sees a deterministic busy window.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    md_sequencer_if.slave  md
);
    typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        nocommit_q, nocommit_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Operands are widened by one bit so a single signed multiplier covers mult and multu.
    logic signed [32:0] a_ext, b_ext;
    logic signed [65:0] prod_full;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    always_comb begin
        a_ext     = {md.MDsign & md.A[31], md.A};
        b_ext     = {md.MDsign & md.B[31], md.B};
        prod_full = a_ext * b_ext;

        // Signed divide works on magnitudes; the quotient sign follows A^B, the remainder follows A.
        a_neg  = md.MDsign & md.A[31];
        b_neg  = md.MDsign & md.B[31];
        a_mag  = a_neg ? (~md.A + 32'd1) : md.A;
        b_mag  = b_neg ? (~md.B + 32'd1) : md.B;
        b_safe = (md.B == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        nocommit_d = nocommit_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            IDLE: begin
                if (md.start && md.MDop == 2'b01) begin
                    pend_d     = prod_full[63:0];
                    nocommit_d = 1'b0;
                    cnt_d      = 5'(MULT_CYCLES);
                    state_d    = MULT;
                end else if (md.start && md.MDop == 2'b10) begin
                    pend_d     = {rem, quot};
                    nocommit_d = (md.B == 32'd0);
                    cnt_d      = 5'(DIV_CYCLES);
                    state_d    = DIV;
                end else if (md.immWrite && !md.start) begin
                    if (md.HIWrite) hi_d = md.A;
                    else            lo_d = md.A;
                end
            end
            MULT, DIV: begin
                if (cnt_q == 5'd1) begin
                    if (!nocommit_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                    cnt_d   = 5'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            pend_q     <= 64'd0;
            nocommit_q <= 1'b0;
            busy_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            nocommit_q <= nocommit_d;
            busy_q     <= busy_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign md.busy  = busy_q;
    assign md.HI    = hi_q;
    assign md.LO    = lo_q;
    assign md.HLOut = md.HIRead ? hi_q : lo_q;
endmodule
